// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared register indices and exception cause codes for the writeback register file
package wb_regfile_pkg;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RSTATUS = 5'd30;
  localparam logic [4:0] REG_RA = 5'd31;
  localparam logic [31:0] EXC_CAUSE_1 = 32'd1;
  localparam logic [31:0] EXC_CAUSE_2 = 32'd2;
  localparam logic [31:0] EXC_CAUSE_3 = 32'd3;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port (regs/rs/we/wr/data in, rd out) with r0 force-to-zero and same-cycle write-through bypass
module regfile_read_port
  import wb_regfile_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]          regs [NREGS],
  input  logic [$clog2(NREGS)-1:0] rs,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] wr,
  input  logic [XLEN-1:0]          data,
  output logic [XLEN-1:0]          rd
);
  always_comb rd = (rs == REG_ZERO) ? '0 : (we && wr == rs) ? data : regs[rs];
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback register file (clock/reset, we/writeReg/data/ovf write port, rs1/rs2 -> rd1/rd2 bypassed reads, exc_valid/exc_cause/exc_count capture with exc_clear)
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int XLEN = 32,
  parameter int CNT_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] writeReg,
  input  logic [XLEN-1:0]          data,
  input  logic                     ovf,
  input  logic [$clog2(NREGS)-1:0] rs1,
  input  logic [$clog2(NREGS)-1:0] rs2,
  output logic [XLEN-1:0]          rd1,
  output logic [XLEN-1:0]          rd2,
  output logic                     exc_valid,
  output logic [XLEN-1:0]          exc_cause,
  output logic [CNT_W-1:0]         exc_count,
  input  logic                     exc_clear
);
  logic [XLEN-1:0] regs [NREGS];
  logic cap;
  always_comb cap = we && ovf && writeReg == REG_RSTATUS;
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && writeReg != REG_ZERO) begin
      regs[writeReg] <= data;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      exc_valid <= 1'b0;
      exc_cause <= '0;
      exc_count <= '0;
    end else if (cap) begin
      exc_valid <= 1'b1;
      exc_cause <= data;
      exc_count <= exc_clear ? CNT_W'(1) : (&exc_count) ? exc_count : exc_count + CNT_W'(1);
    end else if (exc_clear) begin
      exc_valid <= 1'b0;
      exc_cause <= '0;
      exc_count <= '0;
    end
  end
  regfile_read_port #(.NREGS(NREGS), .XLEN(XLEN)) u_rp1 (
    .regs(regs), .rs(rs1), .we(we), .wr(writeReg), .data(data), .rd(rd1)
  );
  regfile_read_port #(.NREGS(NREGS), .XLEN(XLEN)) u_rp2 (
    .regs(regs), .rs(rs2), .we(we), .wr(writeReg), .data(data), .rd(rd2)
  );
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed self-checking bench for wb_regfile
module tb_wb_regfile;
  import wb_regfile_pkg::*;
  logic clock = 1'b0;
  logic reset, we, ovf, exc_clear, exc_valid;
  logic [4:0] writeReg, rs1, rs2;
  logic [31:0] data, rd1, rd2, exc_cause;
  logic [7:0] exc_count;
  int checks = 0;
  int failures = 0;
  wb_regfile dut (
    .clock(clock), .reset(reset), .we(we), .writeReg(writeReg), .data(data), .ovf(ovf),
    .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_count(exc_count), .exc_clear(exc_clear)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic wr(input logic [4:0] r, input logic [31:0] d, input logic o);
    we = 1'b1; writeReg = r; data = d; ovf = o;
  endtask
  task automatic idle();
    we = 1'b0; ovf = 1'b0; exc_clear = 1'b0; writeReg = 5'd0; data = 32'h0;
  endtask
  initial begin
    reset = 1'b1; rs1 = 5'd0; rs2 = 5'd0;
    idle();
    step();
    step();
    reset = 1'b0;
    rs1 = 5'd5;
    #1;
    check("reset_rd1", rd1, 32'h0);
    check("reset_valid", {31'h0, exc_valid}, 32'h0);
    check("reset_cause", exc_cause, 32'h0);
    check("reset_count", {24'h0, exc_count}, 32'h0);
    wr(5'd5, 32'hDEADBEEF, 1'b0);
    step();
    idle(); rs1 = 5'd5; rs2 = 5'd6;
    #1;
    check("r5_read", rd1, 32'hDEADBEEF);
    check("r6_read", rd2, 32'h0);
    wr(REG_ZERO, 32'h1234, 1'b0); rs1 = 5'd0;
    #1;
    check("r0_bypass", rd1, 32'h0);
    step();
    idle();
    #1;
    check("r0_after", rd1, 32'h0);
    wr(5'd7, 32'hA5A5A5A5, 1'b0); rs1 = 5'd7; rs2 = 5'd7;
    #1;
    check("bypass_rd1", rd1, 32'hA5A5A5A5);
    check("bypass_rd2", rd2, 32'hA5A5A5A5);
    step();
    idle();
    #1;
    check("r7_array", rd2, 32'hA5A5A5A5);
    wr(5'd8, 32'h1, 1'b0); rs1 = 5'd8;
    step();
    wr(5'd8, 32'h2, 1'b0);
    #1;
    check("b2b_bypass", rd1, 32'h2);
    step();
    idle();
    #1;
    check("b2b_last", rd1, 32'h2);
    wr(REG_RSTATUS, EXC_CAUSE_2, 1'b1);
    #1;
    check("cap_not_yet", {31'h0, exc_valid}, 32'h0);
    step();
    idle(); rs1 = REG_RSTATUS;
    #1;
    check("cap_valid", {31'h0, exc_valid}, 32'h1);
    check("cap_cause", exc_cause, EXC_CAUSE_2);
    check("cap_count", {24'h0, exc_count}, 32'h1);
    check("cap_r30", rd1, 32'h2);
    wr(REG_RSTATUS, 32'h7, 1'b0);
    step();
    idle();
    #1;
    check("plain_r30_cause", exc_cause, EXC_CAUSE_2);
    check("plain_r30_count", {24'h0, exc_count}, 32'h1);
    check("plain_r30_val", rd1, 32'h7);
    ovf = 1'b1; writeReg = REG_RSTATUS; data = 32'h99;
    step();
    wr(5'd12, 32'h77, 1'b1); rs2 = 5'd12;
    step();
    idle();
    #1;
    check("ovf_ignored_count", {24'h0, exc_count}, 32'h1);
    check("ovf_ignored_cause", exc_cause, EXC_CAUSE_2);
    check("ovf_r12", rd2, 32'h77);
    check("ovf_we0_r30", rd1, 32'h7);
    for (int i = 0; i < 300; i++) begin
      wr(REG_RSTATUS, 32'(i), 1'b1);
      step();
    end
    idle();
    #1;
    check("sat_count", {24'h0, exc_count}, 32'd255);
    check("sat_cause", exc_cause, 32'd299);
    wr(REG_RSTATUS, EXC_CAUSE_3, 1'b1); exc_clear = 1'b1;
    step();
    idle();
    #1;
    check("clr_cap_count", {24'h0, exc_count}, 32'h1);
    check("clr_cap_cause", exc_cause, EXC_CAUSE_3);
    check("clr_cap_valid", {31'h0, exc_valid}, 32'h1);
    exc_clear = 1'b1;
    step();
    idle();
    #1;
    check("clr_valid", {31'h0, exc_valid}, 32'h0);
    check("clr_cause", exc_cause, 32'h0);
    check("clr_count", {24'h0, exc_count}, 32'h0);
    check("clr_keeps_r30", rd1, 32'h3);
    for (int i = 1; i < 32; i++) begin
      wr(5'(i), 32'h100 + 32'(i), i == 30);
      step();
    end
    idle(); rs1 = 5'd9; rs2 = REG_RA;
    #1;
    check("fill_r9", rd1, 32'h109);
    check("fill_r31", rd2, 32'h11F);
    check("fill_valid", {31'h0, exc_valid}, 32'h1);
    reset = 1'b1;
    wr(5'd9, 32'h55, 1'b0);
    step();
    reset = 1'b0;
    idle();
    #1;
    check("rst_valid", {31'h0, exc_valid}, 32'h0);
    check("rst_cause", exc_cause, 32'h0);
    check("rst_count", {24'h0, exc_count}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      #1;
      check($sformatf("rst_rd1_r%0d", i), rd1, 32'h0);
      check($sformatf("rst_rd2_r%0d", 31 - i), rd2, 32'h0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
